// File: rtl/coef_mem_if.sv
// Read/write handshake bundle for the writable coefficient store.
// master drives requests and consumes dout; slave is the store.
interface coef_mem_if #(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 4,
   parameter int DWIDTH_TMP = 32
);
   logic                  wr_en;
   logic [AWIDTH-1:0]     wr_addr;
   logic [DWIDTH_TMP-1:0] wr_data;
   logic                  rd_en;
   logic                  start;
   logic [AWIDTH-1:0]     rd_addr;
   logic [AWIDTH:0]       len;
   logic                  dout_ready;
   logic [DWIDTH-1:0]     dout;
   logic                  dout_valid;
   logic                  sat;
   logic                  busy;
   logic                  done;

   modport master (
      output wr_en, wr_addr, wr_data,
      output rd_en, start, rd_addr, len,
      output dout_ready,
      input  dout, dout_valid, sat, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  rd_en, start, rd_addr, len,
      input  dout_ready,
      output dout, dout_valid, sat, busy, done
   );
endinterface

// File: rtl/coef_mem_seq.sv
// Writable coefficient store with fixed-point readout, saturation,
// and single/burst reads under a valid/ready handshake.
module coef_mem_seq #(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 4,
   parameter int DWIDTH_TMP = 32,
   parameter int IN_FRAC    = 24,
   parameter int OUT_FRAC   = 10
) (
   input logic       clk,
   input logic       rst,
   coef_mem_if.slave bus
);
   localparam int SHIFT = IN_FRAC - OUT_FRAC;
   localparam int DEPTH = 2**AWIDTH;

   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

   state_t                state, state_d;
   logic [DWIDTH_TMP-1:0] mem [DEPTH];
   logic [AWIDTH-1:0]     ptr, ptr_d;
   logic [AWIDTH:0]       cnt, cnt_d;
   logic [DWIDTH-1:0]     dout_q;
   logic                  sat_q, valid_q, zero_q;
   logic                  xfer, load, last, zero_d;
   logic [AWIDTH-1:0]     load_addr;
   logic [DWIDTH_TMP-1:0] word, t;
   logic [DWIDTH-1:0]     cdata;
   logic                  csat;

   // Word is fetched when it is loaded into dout, so it sees
   // the pre-edge contents (read-before-write).
   assign word  = mem[load_addr];
   assign t     = word >> SHIFT;
   assign csat  = |(t >> DWIDTH);
   assign cdata = csat ? '1 : t[DWIDTH-1:0];

   assign xfer = valid_q & bus.dout_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d   = state;
      ptr_d     = ptr;
      cnt_d     = cnt;
      load      = 1'b0;
      load_addr = bus.rd_addr;
      zero_d    = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  state_d = BURST;
                  ptr_d   = bus.rd_addr;
                  cnt_d   = bus.len;
                  load    = 1'b1;
               end else begin
                  zero_d = 1'b1;
               end
            end else if (bus.rd_en) begin
               state_d = SINGLE;
               load    = 1'b1;
            end
         end
         SINGLE: begin
            if (xfer) begin
               last    = 1'b1;
               state_d = IDLE;
            end
         end
         BURST: begin
            if (xfer) begin
               if (cnt == (AWIDTH+1)'(1)) begin
                  last    = 1'b1;
                  state_d = IDLE;
               end else begin
                  ptr_d     = ptr + AWIDTH'(1);
                  cnt_d     = cnt - (AWIDTH+1)'(1);
                  load_addr = ptr + AWIDTH'(1);
                  load      = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         cnt     <= '0;
         dout_q  <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         ptr    <= ptr_d;
         cnt    <= cnt_d;
         zero_q <= zero_d;
         if (load) begin
            dout_q  <= cdata;
            sat_q   <= csat;
            valid_q <= 1'b1;
         end else if (xfer) begin
            dout_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.sat        = sat_q;
   assign bus.dout_valid = valid_q;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = zero_q | last;
endmodule

// File: tb/tb_coef_mem_seq.sv
// Bench for coef_mem_seq: directed cases plus randomized bursts
// scored against an array model of the store.
module tb_coef_mem_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;

   bit [31:0]   mmem [16];
   logic [15:0] seen [$];
   int          ncyc;
   logic [4:0]  pat = 5'b11001;

   coef_mem_if #(.DWIDTH(16), .AWIDTH(4), .DWIDTH_TMP(32)) bus ();

   coef_mem_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // {sat, dout}: value scaled down by 2^14, clipped at 16 bits
   function automatic logic [16:0] model_conv(input bit [31:0] w);
      longint unsigned q;
      q = longint'(w) / 16384;
      if (q >= 65536) return {1'b1, 16'hFFFF};
      return {1'b0, q[15:0]};
   endfunction

   task automatic wr(input int a, input bit [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(a);
      bus.wr_data = d;
      @(posedge clk);
      mmem[a] = d;
      #1;
      bus.wr_en = 1'b0;
   endtask

   // mode: 0 ready high, 1 random ready, 2 ready from pat
   task automatic run_req(input bit single, input int base, input int n,
                          input int mode, input bit rnd_wr, input bit spur,
                          input bit acc_wr, input bit [31:0] acc_data);
      int          got = 0;
      int          cyc = 0;
      int          addr = base;
      int          wa = 0;
      bit          rdy, w;
      bit [31:0]   cur, wd = 0;
      logic [16:0] e;
      seen.delete();
      bus.start      = !single;
      bus.rd_en      = single;
      bus.rd_addr    = 4'(base);
      bus.len        = 5'(n);
      bus.dout_ready = 1'b0;
      if (acc_wr) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 4'(base);
         bus.wr_data = acc_data;
      end
      @(negedge clk);
      chk("acc_busy", bus.busy, 0);
      chk("acc_valid", bus.dout_valid, 0);
      @(posedge clk);
      cur = mmem[base];
      if (acc_wr) mmem[base] = acc_data;
      #1;
      bus.start = 1'b0;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      if (!single && n == 0) begin
         @(negedge clk);
         chk("zero_done", bus.done, 1);
         chk("zero_valid", bus.dout_valid, 0);
         chk("zero_busy", bus.busy, 0);
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("zero_done2", bus.done, 0);
         chk("zero_valid2", bus.dout_valid, 0);
         @(posedge clk);
         #1;
         ncyc = 0;
         return;
      end
      while (got < n && cyc < 200) begin
         if (mode == 0) rdy = 1'b1;
         else if (mode == 1) rdy = 1'($urandom_range(0, 1));
         else rdy = (cyc < 5) ? pat[cyc] : 1'b1;
         bus.dout_ready = rdy;
         w = rnd_wr && ($urandom_range(0, 3) == 0);
         if (w) begin
            wa = $urandom_range(0, 15);
            wd = $urandom >> $urandom_range(0, 3);
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(wa);
            bus.wr_data = wd;
         end
         if (spur) begin
            bus.start   = 1'($urandom_range(0, 1));
            bus.rd_en   = 1'($urandom_range(0, 1));
            bus.rd_addr = 4'($urandom_range(0, 15));
            bus.len     = 5'($urandom_range(0, 16));
         end
         e = model_conv(cur);
         @(negedge clk);
         chk("valid", bus.dout_valid, 1);
         chk("dout", bus.dout, e[15:0]);
         chk("sat", bus.sat, e[16]);
         chk("busy", bus.busy, 1);
         chk("done", bus.done, rdy && (got == n - 1));
         if (rdy) seen.push_back(bus.dout);
         @(posedge clk);
         if (rdy) begin
            got++;
            addr = (addr + 1) % 16;
            if (got < n) cur = mmem[addr];
         end
         if (w) mmem[wa] = wd;
         #1;
         bus.wr_en = 1'b0;
         cyc++;
      end
      chk("timeout", cyc < 200, 1);
      bus.start      = 1'b0;
      bus.rd_en      = 1'b0;
      bus.dout_ready = 1'b0;
      @(negedge clk);
      chk("end_valid", bus.dout_valid, 0);
      chk("end_busy", bus.busy, 0);
      chk("end_done", bus.done, 0);
      chk("end_dout", bus.dout, 0);
      @(posedge clk);
      #1;
      ncyc = cyc;
   endtask

   initial begin
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
      bus.rd_en = 0; bus.start = 0; bus.rd_addr = 0;
      bus.len = 0; bus.dout_ready = 0;
      for (int i = 0; i < 16; i++) mmem[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", bus.dout_valid, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_sat", bus.sat, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      rst = 1'b0;

      wr(0, 32'h0800_0000);
      run_req(1, 0, 1, 0, 0, 0, 0, 0);
      chk("t1_word", seen.size() > 0 ? seen[0] : 16'hDEAD, 16'h2000);

      wr(2, 32'h0500_0000);
      wr(3, 32'h4000_0000);
      run_req(0, 2, 2, 0, 0, 0, 0, 0);
      chk("t2_w0", seen.size() > 0 ? seen[0] : 16'hDEAD, 16'h1400);
      chk("t2_w1", seen.size() > 1 ? seen[1] : 16'hDEAD, 16'hFFFF);

      for (int k = 0; k < 16; k++) wr(k, 32'(k) << 14);
      run_req(0, 14, 4, 0, 0, 0, 0, 0);
      chk("wrap_cyc", ncyc, 4);
      for (int i = 0; i < 4; i++)
         chk("wrap_addr", seen.size() > i ? seen[i] : 16'hDEAD,
             32'((14 + i) % 16));

      run_req(0, 6, 3, 2, 0, 1, 0, 0);
      chk("stall_n", seen.size(), 3);
      chk("stall_cyc", ncyc, 5);

      run_req(0, 9, 0, 0, 0, 0, 0, 0);

      bus.start   = 1'b1;
      bus.rd_addr = 4'd0;
      bus.len     = 5'd8;
      @(posedge clk);
      #1;
      bus.start      = 1'b0;
      bus.dout_ready = 1'b1;
      @(posedge clk);
      #2;
      chk("pre_rst_valid", bus.dout_valid, 1);
      rst = 1'b1;
      #1;
      chk("arst_valid", bus.dout_valid, 0);
      chk("arst_dout", bus.dout, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      chk("arst_sat", bus.sat, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.dout_ready = 1'b0;
      for (int i = 0; i < 16; i++) mmem[i] = 0;
      @(negedge clk);
      chk("post_rst_done", bus.done, 0);
      @(posedge clk);
      #1;
      run_req(1, 3, 1, 0, 0, 0, 0, 0);
      chk("cleared", seen.size() > 0 ? seen[0] : 16'hDEAD, 0);

      wr(5, 32'h0100_0000);
      run_req(1, 5, 1, 0, 0, 0, 1, 32'h0200_0000);
      chk("rbw_old", seen.size() > 0 ? seen[0] : 16'hDEAD, 16'h0400);
      run_req(1, 5, 1, 0, 0, 0, 0, 0);
      chk("rbw_new", seen.size() > 0 ? seen[0] : 16'hDEAD, 16'h0800);

      for (int k = 0; k < 16; k++) wr(k, $urandom >> $urandom_range(0, 3));
      run_req(0, $urandom_range(0, 15), 16, 1, 1, 1, 0, 0);
      chk("full_n", seen.size(), 16);

      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(0, 2) == 0)
            run_req(1, $urandom_range(0, 15), 1, 1, 1, 1, 0, 0);
         else
            run_req(0, $urandom_range(0, 15), $urandom_range(0, 16),
                    1, 1, 1, 0, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/coef_mem_seq.md
Name: coef_mem_seq

Overview:
Parametrised, writable coefficient store for the backprop neural-network datapath. It replaces fixed coefficient ROMs such as the k1 table. Words are held in Q(DWIDTH_TMP-IN_FRAC).IN_FRAC unsigned format and are converted on readout to DWIDTH-bit unsigned fixed point with OUT_FRAC fraction bits, with saturation. The block supports single-word reads and streamed bursts with wrap-around, both under a valid/ready handshake.

Parameters:
DWIDTH, 16, output data width
AWIDTH, 4, address width; depth = 2**AWIDTH
DWIDTH_TMP, 32, stored word width
IN_FRAC, 24, fraction bits of stored word
OUT_FRAC, 10, fraction bits of output (IN_FRAC >= OUT_FRAC)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  write strobe
wr_addr  in  AWIDTH  write address
wr_data  in  DWIDTH_TMP  write data
rd_en  in  1  single-word read request (ignored unless IDLE)
start  in  1  burst request (ignored unless IDLE)
rd_addr  in  AWIDTH  read/burst base address, sampled with rd_en/start
len  in  AWIDTH+1  burst length 0..2**AWIDTH, sampled with start
dout_ready  in  1  consumer ready
dout  out  DWIDTH  converted coefficient
dout_valid  out  1  dout holds a word
sat  out  1  current dout was saturated (qualified by dout_valid)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on final transfer of a request

Behaviour:
- Reset is asynchronous and active-high. All memory words go to 0, the state goes to IDLE, and dout, dout_valid, sat, busy and done all go to 0. A reset mid-burst aborts the burst with no done pulse.
- Writes:
  - mem[wr_addr] <= wr_data at the clock edge when wr_en=1, in any state.
  - A read in the same cycle from the same address returns the old word (read-before-write).
- Conversion:
  - t = word >> (IN_FRAC-OUT_FRAC), truncating.
  - If t >= 2**DWIDTH, dout = all ones and sat = 1; otherwise dout = t[DWIDTH-1:0] and sat = 0.
  - With the defaults, dout = word[29:14], saturating if word[31:30] != 0.
- Outputs are never tri-stated. When dout_valid = 0, dout = 0 and sat = 0.
- Transfer rule: a word is transferred on any cycle with dout_valid && dout_ready.
- dout, sat and dout_valid hold stable while dout_valid && !dout_ready.
- FSM states: IDLE, SINGLE, BURST.
  - IDLE, start=1 with len>0 → BURST. Capture ptr = rd_addr and cnt = len. The first word is valid on the next cycle (1-cycle latency).
  - IDLE, start=1 with len=0 → no valid word. done pulses on the next cycle and the state stays IDLE.
  - IDLE, rd_en=1 (start=0) → SINGLE. dout_valid = 1 on the next cycle.
  - IDLE, start and rd_en both 1 → start wins.
  - SINGLE: on transfer, done = 1 in the same cycle. dout_valid drops on the next cycle unless a new request is accepted. Return to IDLE.
  - BURST: on each transfer, ptr <= ptr+1 (mod 2**AWIDTH) and cnt <= cnt-1. The next word is presented on the following cycle, so full throughput with ready held high is one word per cycle.
  - BURST, transfer with cnt = 1 → done = 1 in the same cycle as the last transfer, then IDLE.
  - len = 2**AWIDTH reads every entry exactly once, starting at rd_addr.
- Back-to-back requests: start/rd_en asserted in the final-transfer cycle are ignored, because the block is not yet IDLE. The next request is accepted one cycle later. The minimum gap between requests is therefore one idle cycle.
- busy = 1 from the cycle after acceptance through the final-transfer cycle.
- Data coherency: each burst word is read at the time it is presented. A write to a not-yet-read burst address changes the streamed value.
- If dout_ready is held low indefinitely, the block holds its current word with no timeout.

Test Plan:
- Reset, then write mem[0]=0x08000000 and rd_en at addr 0 with ready=1 → next cycle: dout=0x2000, dout_valid=1, sat=0, done=1.
- Write 0x05000000 to addr 2 and 0x40000000 to addr 3; burst rd_addr=2, len=2, ready=1 → dout 0x1400 (sat=0), then 0xFFFF (sat=1) with done=1 on the second cycle.
- Write words k to addr k for all k; burst rd_addr=14, len=4 → addresses 14, 15, 0, 1 in order, consecutive cycles, done on the fourth word.
- Burst len=3 with ready toggling 1,0,0,1,1 → dout held during the low cycles, exactly 3 transfers, done coincident with the third; start/rd_en during busy ignored.
- Burst start with len=0 → dout_valid never asserts and done pulses the next cycle. Separately, assert rst mid-burst → all outputs 0 immediately (asynchronously), memory cleared, no done pulse.
- Same-cycle write/read at addr 5 (old 0x01000000, new 0x02000000) → dout=0x0400. A subsequent read → 0x0800.
